// File: rtl/fetch_queue_pkg.sv
// Shared core types for the instruction fetch path.
package fetch_queue_pkg;
   localparam int unsigned INSTR_BYTES = 4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetcher_output;
endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// Single-clock FIFO with a synchronous flush. Storage is not reset, only the pointers are.
module sync_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 64,
   localparam int unsigned AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic [AW:0]      count_o,
   output logic             full_o,
   output logic             empty_o
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             push_ok, pop_ok;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (AW+1)'(DEPTH));
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];

   // A push into a full queue is legal only when the head leaves in the same cycle.
   assign pop_ok  = pop_i && !empty_o;
   assign push_ok = push_i && (!full_o || pop_ok);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset || flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push_ok && !flush_i) mem_q[wr_ptr_q] <= data_i;
   end
endmodule

// File: rtl/fetch_queue.sv
// Prefetching instruction fetcher: one outstanding memory read, DEPTH-entry buffer to decode,
// redirect flushes the buffer and discards the response of any read already in flight.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   localparam int unsigned AW = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          redirect_valid,
   input  logic [31:0]   redirect_pc,
   output logic          out_valid,
   input  logic          out_ready,
   output fetcher_output out,
   output logic          mem_ready,
   input  logic          mem_valid,
   input  logic [31:0]   mem_rdata,
   output logic          mem_instr,
   output logic [31:0]   mem_addr,
   output logic [3:0]    mem_wstrb
);
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   addr_q, addr_d;
   logic          inflight_q, inflight_d;
   logic          discard_q, discard_d;
   logic          resp, push, pop, issue;
   logic          fifo_full, fifo_empty;
   logic [AW:0]   fifo_count;
   logic [63:0]   fifo_head;
   fetcher_output push_entry;
   logic          redir_lsb_unused;

   assign redir_lsb_unused = ^redirect_pc[1:0];

   always_comb begin
      resp  = mem_valid && inflight_q;
      // Anything returning during a redirect or for a pre-redirect read is stale.
      push  = resp && !discard_q && !redirect_valid;
      pop   = out_valid && out_ready;
      // Issue is held off in the redirect cycle so the first fetch uses the new PC.
      issue = !inflight_q && !redirect_valid && !fifo_full;

      push_entry.pc    = addr_q;
      push_entry.instr = mem_rdata;

      fetch_pc_d = fetch_pc_q;
      addr_d     = addr_q;
      inflight_d = inflight_q;
      discard_d  = discard_q;

      if (redirect_valid)  fetch_pc_d = {redirect_pc[31:2], 2'b00};
      else if (issue)      fetch_pc_d = fetch_pc_q + 32'(INSTR_BYTES);

      if (issue) begin
         inflight_d = 1'b1;
         addr_d     = fetch_pc_q;
      end else if (resp) begin
         inflight_d = 1'b0;
      end

      if (resp)                             discard_d = 1'b0;
      else if (redirect_valid && inflight_q) discard_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fetch_pc_q <= RESET_PC;
         addr_q     <= '0;
         inflight_q <= 1'b0;
         discard_q  <= 1'b0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         addr_q     <= addr_d;
         inflight_q <= inflight_d;
         discard_q  <= discard_d;
      end
   end

   sync_fifo #(.DEPTH(DEPTH), .WIDTH(64)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .flush_i (redirect_valid),
      .push_i  (push),
      .data_i  (push_entry),
      .pop_i   (pop),
      .data_o  (fifo_head),
      .count_o (fifo_count),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   assign out_valid = !fifo_empty;
   assign out       = fetcher_output'(fifo_head);
   assign mem_ready = inflight_q;
   assign mem_instr = inflight_q;
   assign mem_addr  = addr_q;
   assign mem_wstrb = 4'b0000;

   a_wstrb_zero: assert property (@(posedge clk) mem_wstrb == 4'b0000);
   a_addr_stable: assert property (@(posedge clk) disable iff (reset)
      (mem_ready && !mem_valid) |=> $stable(mem_addr));
   a_count_max: assert property (@(posedge clk) 32'(fifo_count) <= DEPTH);
   a_no_push_discard: assert property (@(posedge clk) disable iff (reset)
      !(push && discard_q));
endmodule
